// File: rtl/beat_sequencer.sv
// ---------------------------------------------------------------------------
// beat_sequencer
//
// Timing generator for the instruction decoder. Every instruction is a
// 4-beat fetch cycle (quick=1) followed by a 4-beat execute cycle (quick=0).
// The active beat is presented one-hot on slow (1000,0100,0010,0001).
// Supports free-run and single-step. A beat is held while the decoder
// requests a memory access that has not completed. The machine stops on the
// halt opcode or on a memory wait timeout.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   run          level, execute instructions continuously
//   step         one-cycle pulse, run exactly one instruction from IDLE
//   ir           current instruction register contents
//   mem_rw       decoder W,R bits for the current beat (nonzero = access)
//   mem_ready    memory has completed the current access
//   slow         one-hot beat to decoder, 0000 when not sequencing
//   quick        1 = fetch cycle, 0 = execute cycle
//   busy         high while fetching or executing
//   halted       high in HALT
//   bus_err      sticky memory wait timeout flag
//   instr_count  retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module beat_sequencer #(
    parameter logic [7:0] HALT_OPCODE = 8'hFF,
    parameter int         WAIT_MAX    = 15,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [7:0]       ir,
    input  logic [1:0]       mem_rw,
    input  logic             mem_ready,
    output logic [3:0]       slow,
    output logic             quick,
    output logic             busy,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             r_state;
    logic [3:0]         r_slow;
    logic               r_quick;
    logic               r_busy;
    logic               r_halted;
    logic               r_bus_err;
    logic [CNT_W-1:0]   r_count;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_step;     // current instruction was started by step

    logic               w_active;
    logic               w_stall;
    logic [WAIT_W-1:0]  w_wait_next;
    logic               w_timeout;
    logic               w_last_beat;

    assign w_active    = (r_state == S_FETCH) || (r_state == S_EXEC);
    assign w_stall     = w_active && (mem_rw != 2'b00) && !mem_ready;
    assign w_wait_next = r_wait + 1'b1;
    // The stall that brings the counter up to WAIT_MAX is the one that
    // trips the timeout, so the machine halts on that same edge.
    assign w_timeout   = w_stall && (w_wait_next == WAIT_W'(WAIT_MAX));
    assign w_last_beat = r_slow[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_slow    <= 4'b0000;
            r_quick   <= 1'b1;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
            r_bus_err <= 1'b0;
            r_count   <= '0;
            r_wait    <= '0;
            r_step    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // run has priority over step; a step latched here
                    // returns the machine to IDLE after one instruction.
                    if (run || step) begin
                        r_state <= S_FETCH;
                        r_slow  <= 4'b1000;
                        r_quick <= 1'b1;
                        r_busy  <= 1'b1;
                        r_wait  <= '0;
                        r_step  <= !run;
                    end
                end

                S_FETCH, S_EXEC: begin
                    if (w_stall) begin
                        if (w_timeout) begin
                            r_state   <= S_HALT;
                            r_slow    <= 4'b0000;
                            r_quick   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_halted  <= 1'b1;
                            r_bus_err <= 1'b1;
                            r_wait    <= '0;
                        end else begin
                            r_wait <= w_wait_next;
                        end
                    end else begin
                        r_wait <= '0;
                        if (!w_last_beat) begin
                            r_slow <= r_slow >> 1;
                        end else if (r_state == S_FETCH) begin
                            r_state <= S_EXEC;
                            r_slow  <= 4'b1000;
                            r_quick <= 1'b0;
                        end else begin
                            // Leaving the final execute beat retires the
                            // instruction; ir is sampled on this edge.
                            r_count <= r_count + 1'b1;
                            if (ir == HALT_OPCODE) begin
                                r_state  <= S_HALT;
                                r_slow   <= 4'b0000;
                                r_quick  <= 1'b1;
                                r_busy   <= 1'b0;
                                r_halted <= 1'b1;
                                r_step   <= 1'b0;
                            end else if (r_step) begin
                                r_state <= S_IDLE;
                                r_slow  <= 4'b0000;
                                r_quick <= 1'b1;
                                r_busy  <= 1'b0;
                                r_step  <= 1'b0;
                            end else if (run) begin
                                // Back-to-back instruction, no idle gap.
                                r_state <= S_FETCH;
                                r_slow  <= 4'b1000;
                                r_quick <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_slow  <= 4'b0000;
                                r_quick <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end

                S_HALT: begin
                    // Terminal until reset; run and step are ignored.
                    r_slow  <= 4'b0000;
                    r_quick <= 1'b1;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_slow  <= 4'b0000;
                    r_quick <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign slow        = r_slow;
    assign quick       = r_quick;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign bus_err     = r_bus_err;
    assign instr_count = r_count;

endmodule

// File: tb/tb_beat_sequencer.sv
// ---------------------------------------------------------------------------
// tb_beat_sequencer
//
// Directed stimulus with hand-computed expectations. Each expectation is
// tagged with the clock cycle after which it must be visible; a separate
// monitor pops and compares on the falling edge (and right after an
// asynchronous reset assertion, with no clock edge in between).
// ---------------------------------------------------------------------------
module tb_beat_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  ir = 8'h00;
    logic [1:0]  mem_rw = 2'b00;
    logic        mem_ready = 1'b1;
    logic [3:0]  slow;
    logic        quick;
    logic        busy;
    logic        halted;
    logic        bus_err;
    logic [15:0] instr_count;

    beat_sequencer #(
        .HALT_OPCODE (8'hFF),
        .WAIT_MAX    (15),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .ir          (ir),
        .mem_rw      (mem_rw),
        .mem_ready   (mem_ready),
        .slow        (slow),
        .quick       (quick),
        .busy        (busy),
        .halted      (halted),
        .bus_err     (bus_err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        string       name;
        logic [3:0]  slow;
        logic        quick;
        logic        busy;
        logic        halted;
        logic        berr;
        logic [15:0] cnt;
    } exp_t;

    exp_t  q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    string phase = "init";

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input int tag, input logic [3:0] s, input logic qk,
                            input logic b, input logic h, input logic e,
                            input logic [15:0] c);
        exp_t x;
        x.tag = tag; x.name = phase; x.slow = s; x.quick = qk;
        x.busy = b; x.halted = h; x.berr = e; x.cnt = c;
        q.push_back(x);
    endtask

    // Expect the given outputs after the next rising edge, then advance.
    task automatic tick(input logic [3:0] s, input logic qk, input logic b,
                        input logic h, input logic e, input logic [15:0] c);
        push_exp(cyc + 1, s, qk, b, h, e, c);
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges; outputs must drop with no clock edge.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        push_exp(cyc, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        rst = 1'b1;
        push_exp(cyc + 1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            while (q.size() > 0 && q[0].tag <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.tag < cyc) begin
                    errors++;
                    $display("FAIL %s stale expectation tag=%0d at cycle %0d", e.name, e.tag, cyc);
                end else if ({slow, quick, busy, halted, bus_err, instr_count} !==
                             {e.slow, e.quick, e.busy, e.halted, e.berr, e.cnt}) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got slow=%b quick=%b busy=%b halted=%b bus_err=%b cnt=%0d want slow=%b quick=%b busy=%b halted=%b bus_err=%b cnt=%0d",
                             e.name, cyc, slow, quick, busy, halted, bus_err, instr_count,
                             e.slow, e.quick, e.busy, e.halted, e.berr, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        phase = "reset";
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        rst = 1'b0;
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

        // Free run, then drop run mid-instruction: it still completes
        phase = "freerun";
        ir  = 8'h06;
        run = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k == 25) run = 1'b0;
            tick(4'b1000 >> (k % 4), (k % 8) < 4, 1'b1, 1'b0, 1'b0, 16'(k / 8));
        end
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4);

        // Single step; a second pulse while busy is ignored
        phase = "step";
        ir   = 8'h02;
        step = 1'b1;
        tick(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4);
        for (int k = 1; k < 8; k++) begin
            step = (k == 3);
            tick(4'b1000 >> (k % 4), k < 4, 1'b1, 1'b0, 1'b0, 16'd4);
        end
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5);
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5);

        // Memory stall on fetch beat 0010 for 3 clocks
        phase = "stall";
        ir  = 8'h06;
        run = 1'b1;
        tick(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5);
        tick(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5);
        tick(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5);
        mem_rw    = 2'b01;
        mem_ready = 1'b0;
        repeat (3) tick(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5);
        mem_ready = 1'b1;
        tick(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5);
        mem_rw = 2'b00;
        run    = 1'b0;
        for (int k = 0; k < 4; k++)
            tick(4'b1000 >> k, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5);
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd6);

        // Bus timeout: 14 held stalls, the 15th halts with bus_err
        phase = "timeout";
        run = 1'b1;
        tick(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd6);
        mem_rw    = 2'b10;
        mem_ready = 1'b0;
        repeat (14) tick(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd6);
        tick(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'd6);
        mem_rw    = 2'b00;
        mem_ready = 1'b1;
        run = 1'b0;
        tick(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'd6);
        run = 1'b1;
        tick(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'd6);
        step = 1'b1;
        tick(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'd6);
        step = 1'b0;
        tick(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'd6);

        phase = "reset2";
        apply_reset();
        run = 1'b0;
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

        // Halt opcode: execute completes and retires, then HALT
        phase = "haltop";
        ir  = 8'hFF;
        run = 1'b1;
        for (int k = 0; k < 8; k++)
            tick(4'b1000 >> (k % 4), k < 4, 1'b1, 1'b0, 1'b0, 16'd0);
        tick(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
        run = 1'b0;
        tick(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);

        phase = "reset3";
        apply_reset();
        ir = 8'h06;
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

        // Async reset while on execute beat 0100
        phase = "async";
        run = 1'b1;
        for (int k = 0; k < 6; k++)
            tick(4'b1000 >> (k % 4), k < 4, 1'b1, 1'b0, 1'b0, 16'd0);
        apply_reset();
        run = 1'b0;
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

        repeat (2) @(negedge clk);
        #3;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain %0d expectations never compared", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Timing generator that drives the instruction decoder's `slow` (one-hot beat) and `quick` (fetch-cycle) inputs.
- Sequences each instruction as a 4-beat fetch cycle followed by a 4-beat execute cycle.
- Supports free-run and single-step, stalls on unfinished memory transfers, and stops on the halt opcode or a bus timeout.
- Sits between the front-panel/run control and the control unit; reads back IR and the decoder's memory W/R bits.

Parameters:
- HALT_OPCODE, 8'hFF, IR value that stops the machine after its execute cycle completes.
- WAIT_MAX, 15, maximum consecutive stall cycles on one beat before a bus error is flagged.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level; high = execute instructions continuously.
- step  input  1  one-cycle pulse; run exactly one instruction from IDLE.
- ir  input  8  current instruction register contents.
- mem_rw  input  2  decoder control word bits [1:0] (W,R) for the current beat; nonzero = memory access.
- mem_ready  input  1  memory has completed the current access.
- slow  output  4  one-hot beat to decoder (1000,0100,0010,0001), 0000 when not sequencing.
- quick  output  1  1 = fetch cycle, 0 = execute cycle.
- busy  output  1  high while in FETCH or EXEC.
- halted  output  1  high in HALT state.
- bus_err  output  1  sticky; set on memory wait timeout.
- instr_count  output  CNT_W  retired-instruction counter.

Behaviour:
- Reset values: state IDLE, slow=0000, quick=1, busy=0, halted=0, bus_err=0, instr_count=0, wait counter=0, step latch=0.
- States: IDLE, FETCH, EXEC, HALT. All outputs are registered; slow/quick reflect the current state and beat.
- IDLE: slow=0000, quick=1.
  - run=1 → next cycle FETCH, beat 1000.
  - step=1 with run=0 → FETCH, beat 1000, step latch=1.
  - run and step both high → run wins; step latch stays 0.
- Beat advance: 1000→0100→0010→0001, one beat per clock unless stalled.
- Stall: if mem_rw≠00 and mem_ready=0, hold slow/quick and increment the wait counter.
  - The wait counter clears whenever a beat advances.
  - If the wait counter reaches WAIT_MAX while still stalled → set bus_err, go to HALT next cycle.
- FETCH: quick=1. After beat 0001 → EXEC beat 1000, quick=0.
- EXEC: quick=0. On leaving beat 0001, instr_count increments by 1 (wraps modulo 2^CNT_W). Next state is chosen from ir sampled on that same clock:
  - ir==HALT_OPCODE → HALT.
  - else step latch=1 → IDLE, clear step latch.
  - else run=1 → FETCH beat 1000, with no idle gap.
  - else → IDLE.
- run falling mid-instruction: the current instruction always completes through EXEC beat 0001; no beat is ever truncated.
- step pulses while busy or halted are ignored.
- HALT: slow=0000, quick=1, busy=0, halted=1. Exits only via rst. bus_err holds until rst.
- Reset mid-instruction: immediate return to reset values; no partial count increment.
- Latency: run rising in IDLE → slow=1000 on the next clock edge. An unstalled instruction takes 8 clocks.

Test Plan:
- Free run: rst, run=1, ir=8'h06, mem_ready=1 → slow sequence 1000,0100,0010,0001 with quick=1, then the same with quick=0; repeats; instr_count=3 after 24 clocks.
- Single step: run=0, step pulse, ir=8'h02 → exactly 8 beats, then IDLE (slow=0000, busy=0), instr_count=1; a second step while busy is ignored.
- Memory stall: mem_rw=01 on FETCH beat 0010, mem_ready low for 3 clocks → slow holds 0010 for 4 clocks, then advances to 0001; bus_err=0.
- Timeout: mem_rw=10, mem_ready stuck at 0 → after 15 stall cycles, bus_err=1, halted=1, slow=0000; run toggling has no effect until rst.
- Halt opcode: ir=8'hFF during EXEC → beat 0001 completes, instr_count increments, halted=1, slow=0000.
- Async reset mid-EXEC beat 0100 → outputs return to reset values immediately without a clock edge; instr_count unchanged from 0 after reset.
